// File: rtl/slot_bus_master.sv
// slot_bus_master: MSX slot-bus initiator turning single requests into Z80-timed memory cycles (optional wait support: SLOT_NWAIT_EN)
//   clk, slot_nreset            : system clock, async active-low reset
//   req_valid/ready/write/address/wdata : request handshake (accepted only in IDLE)
//   rsp_valid/rdata/error       : one-cycle completion pulse, read data, wait-timeout flag
//   slot_a, slot_d_out/oe/in    : address bus, data bus (tristated at top level via slot_d_oe)
//   slot_nmerq/nsltsl/nrd/nwr   : active-low bus strobes
//   slot_nwait                  : active-low wait request, honoured only when SLOT_NWAIT_EN is defined
module slot_bus_master #(
  parameter int CLK_DIV  = 6,
  parameter int MAX_WAIT = 255
) (
  input  logic        clk,
  input  logic        slot_nreset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [15:0] req_address,
  input  logic [7:0]  req_wdata,
  output logic        rsp_valid,
  output logic [7:0]  rsp_rdata,
  output logic        rsp_error,
  output logic [15:0] slot_a,
  output logic [7:0]  slot_d_out,
  output logic        slot_d_oe,
  input  logic [7:0]  slot_d_in,
  output logic        slot_nmerq,
  output logic        slot_nsltsl,
  output logic        slot_nrd,
  output logic        slot_nwr,
  input  logic        slot_nwait
);
  localparam int HALF = CLK_DIV / 2;
  localparam int CW   = $clog2(3 * CLK_DIV);
  localparam logic [2:0] IDLE = 3'd0, T1 = 3'd1, T2 = 3'd2, TW = 3'd3, T3 = 3'd4, END = 3'd5;
  // Registered outputs change on the edge that ends the cycle before each window opens.
  localparam logic [CW-1:0] C_LOW  = CW'(HALF - 1);
  localparam logic [CW-1:0] C_T1E  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0] C_WR   = CW'(CLK_DIV + HALF - 1);
  localparam logic [CW-1:0] C_T2E  = CW'(2 * CLK_DIV - 1);
  localparam logic [CW-1:0] C_REL  = CW'(2 * CLK_DIV + HALF - 1);
  localparam logic [CW-1:0] C_PRE  = CW'(3 * CLK_DIV - 2);
  localparam logic [CW-1:0] C_LAST = CW'(3 * CLK_DIV - 1);
  logic [2:0]    state;
  logic [CW-1:0] cyc;
  logic          wr;
  logic [7:0]    wdata;
  logic          tmo;
`ifdef SLOT_NWAIT_EN
  localparam int TWW = $clog2(CLK_DIV);
  localparam logic [TWW-1:0] TW_LAST = TWW'(CLK_DIV - 1);
  logic [7:0]     wcnt;
  logic [TWW-1:0] twc;
`else
  logic unused_nwait;
  assign unused_nwait = slot_nwait | (MAX_WAIT == 0) | (state == TW);
  assign tmo = 1'b0;
`endif
  always_ff @(posedge clk or negedge slot_nreset) begin
    if (!slot_nreset) begin
      state       <= IDLE;
      cyc         <= '0;
      wr          <= 1'b0;
      wdata       <= 8'h00;
      slot_a      <= 16'h0000;
      slot_d_out  <= 8'h00;
      slot_d_oe   <= 1'b0;
      slot_nmerq  <= 1'b1;
      slot_nsltsl <= 1'b1;
      slot_nrd    <= 1'b1;
      slot_nwr    <= 1'b1;
      req_ready   <= 1'b1;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= 8'h00;
      rsp_error   <= 1'b0;
`ifdef SLOT_NWAIT_EN
      wcnt        <= 8'h00;
      twc         <= '0;
      tmo         <= 1'b0;
`endif
    end else begin
      rsp_valid <= 1'b0;
      if (state == IDLE) begin
        if (req_valid) begin
          state     <= T1;
          cyc       <= '0;
          slot_a    <= req_address;
          wr        <= req_write;
          wdata     <= req_wdata;
          req_ready <= 1'b0;
`ifdef SLOT_NWAIT_EN
          wcnt      <= 8'h00;
          tmo       <= 1'b0;
`endif
        end
      end else begin
        if (cyc == C_LOW) begin
          slot_nmerq  <= 1'b0;
          slot_nsltsl <= 1'b0;
          slot_nrd    <= wr;
          if (wr) begin
            slot_d_out <= wdata;
            slot_d_oe  <= 1'b1;
          end
        end
        if (wr && cyc == C_WR)
          slot_nwr <= 1'b0;
        if (cyc == C_REL) begin
          slot_nmerq  <= 1'b1;
          slot_nsltsl <= 1'b1;
          slot_nrd    <= 1'b1;
          slot_nwr    <= 1'b1;
          if (!wr || tmo)
            rsp_rdata <= tmo ? 8'hFF : slot_d_in;
        end
        if (cyc == C_LAST) begin
          slot_d_oe <= 1'b0;
          rsp_valid <= 1'b1;
          rsp_error <= tmo;
          req_ready <= 1'b1;
          state     <= IDLE;
        end else if (cyc == C_T2E) begin
`ifdef SLOT_NWAIT_EN
          // cyc stays frozen while TW states run; each TW lasts CLK_DIV clocks.
          if (state == TW && twc != TW_LAST) begin
            twc <= twc + 1'b1;
          end else if (!slot_nwait && wcnt != 8'(MAX_WAIT)) begin
            state <= TW;
            twc   <= '0;
            wcnt  <= wcnt + 1'b1;
          end else begin
            state <= T3;
            cyc   <= cyc + 1'b1;
            tmo   <= !slot_nwait;
          end
`else
          state <= T3;
          cyc   <= cyc + 1'b1;
`endif
        end else begin
          cyc <= cyc + 1'b1;
          if (cyc == C_T1E)
            state <= T2;
          if (cyc == C_PRE)
            state <= END;
        end
      end
    end
  end
endmodule

// File: tb/tb_slot_bus_master.sv
// tb_slot_bus_master: directed table-driven check of slot_bus_master cycle timing, back-to-back, reset and wait handling
module tb_slot_bus_master;
  logic        clk = 1'b0;
  logic        slot_nreset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_write = 1'b0;
  logic [15:0] req_address = 16'h0000;
  logic [7:0]  req_wdata = 8'h00;
  logic        rsp_valid;
  logic [7:0]  rsp_rdata;
  logic        rsp_error;
  logic [15:0] slot_a;
  logic [7:0]  slot_d_out;
  logic        slot_d_oe;
  logic [7:0]  slot_d_in = 8'h00;
  logic        slot_nmerq;
  logic        slot_nsltsl;
  logic        slot_nrd;
  logic        slot_nwr;
  logic        slot_nwait = 1'b1;

  slot_bus_master #(.CLK_DIV(6), .MAX_WAIT(3)) dut (
    .clk(clk), .slot_nreset(slot_nreset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_address(req_address), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .slot_a(slot_a), .slot_d_out(slot_d_out), .slot_d_oe(slot_d_oe), .slot_d_in(slot_d_in),
    .slot_nmerq(slot_nmerq), .slot_nsltsl(slot_nsltsl), .slot_nrd(slot_nrd), .slot_nwr(slot_nwr),
    .slot_nwait(slot_nwait)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        wr;
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  din;
    logic        nw;
  } vec_t;

`ifdef SLOT_NWAIT_EN
  localparam logic NW_IGN = 1'b1;
`else
  localparam logic NW_IGN = 1'b0;
`endif

  int passed = 0;
  int total = 0;
  logic [7:0] last_rd = 8'h00;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  // Drives one request and checks every cycle from accept+1 up to the response.
  task automatic run(input vec_t v);
    int n;
    logic in_low;
    n = 0;
    @(negedge clk);
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("ready before accept", req_ready, 1);
    req_write = v.wr; req_address = v.addr; req_wdata = v.wdata;
    slot_d_in = v.din; slot_nwait = v.nw; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0; req_address = 16'hDEAD; req_write = ~v.wr;
    if (!v.wr) last_rd = v.din;
    for (int c = 0; c <= 18; c++) begin
      in_low = (c >= 3 && c <= 14);
      chk($sformatf("slot_a c%0d", c), slot_a, v.addr);
      chk($sformatf("nmerq c%0d", c), slot_nmerq, !in_low);
      chk($sformatf("nsltsl c%0d", c), slot_nsltsl, !in_low);
      chk($sformatf("nrd c%0d", c), slot_nrd, !(in_low && !v.wr));
      chk($sformatf("nwr c%0d", c), slot_nwr, !(v.wr && c >= 9 && c <= 14));
      chk($sformatf("d_oe c%0d", c), slot_d_oe, v.wr && c >= 3 && c <= 17);
      if (v.wr && c >= 3) chk($sformatf("d_out c%0d", c), slot_d_out, v.wdata);
      chk($sformatf("rsp_valid c%0d", c), rsp_valid, c == 18);
      chk($sformatf("req_ready c%0d", c), req_ready, c == 18);
      if (c == 18) begin
        chk("rsp_error", rsp_error, 0);
        chk("rsp_rdata", rsp_rdata, last_rd);
      end
      if (c < 18) @(negedge clk);
    end
    slot_nwait = 1'b1;
  endtask

  vec_t vecs [6];

  initial begin
    int acc, nrsp, t1, t2;
    logic sw, drop;
    vecs[0] = '{1'b1, 16'h5000, 8'h2A, 8'h00, 1'b1};
    vecs[1] = '{1'b0, 16'h4000, 8'h00, 8'h5A, 1'b1};
    vecs[2] = '{1'b0, 16'h8001, 8'h00, 8'hC3, NW_IGN};
    vecs[3] = '{1'b1, 16'hFFFF, 8'hFF, 8'h00, 1'b1};
    vecs[4] = '{1'b0, 16'h0000, 8'h00, 8'h00, 1'b1};
    vecs[5] = '{1'b1, 16'h1234, 8'h80, 8'hFF, 1'b1};

    #1 slot_nreset = 1'b0;
    @(negedge clk);
    chk("rst slot_a", slot_a, 16'h0000);
    chk("rst d_out", slot_d_out, 8'h00);
    chk("rst d_oe", slot_d_oe, 0);
    chk("rst strobes", {slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr}, 4'hF);
    chk("rst ready", req_ready, 1);
    chk("rst rsp", {rsp_valid, rsp_error, rsp_rdata}, 10'h000);
    @(negedge clk);
    slot_nreset = 1'b1;

    for (int i = 0; i < 6; i++) run(vecs[i]);

    // Back-to-back with req_valid held high.
    @(negedge clk);
    slot_d_in = 8'h77;
    req_write = 1'b1; req_address = 16'h6000; req_wdata = 8'h01; req_valid = 1'b1;
    acc = 0; nrsp = 0; t1 = 0; t2 = 0; sw = 1'b0; drop = 1'b0;
    for (int i = 0; i < 60; i++) begin
      if (sw) begin req_write = 1'b0; req_address = 16'h6001; sw = 1'b0; end
      if (drop) begin req_valid = 1'b0; drop = 1'b0; chk("b2b slot_a", slot_a, 16'h6001); end
      if (rsp_valid) begin
        nrsp++;
        if (nrsp == 1) t1 = i;
        else begin t2 = i; chk("b2b rdata", rsp_rdata, 8'h77); end
      end
      if (req_valid && req_ready) begin
        acc++;
        if (acc == 1) sw = 1'b1; else drop = 1'b1;
      end
      @(negedge clk);
    end
    chk("b2b accepts", 16'(acc), 2);
    chk("b2b responses", 16'(nrsp), 2);
    chk("b2b spacing", 16'(t2 - t1), 19);
    last_rd = 8'h77;

    // Asynchronous reset in the middle of a write.
    req_write = 1'b1; req_address = 16'h7000; req_wdata = 8'h3C; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    repeat (10) @(negedge clk);
    chk("mid nwr low", slot_nwr, 0);
    chk("mid d_oe", slot_d_oe, 1);
    #1 slot_nreset = 1'b0;
    #1;
    chk("async strobes", {slot_nmerq, slot_nsltsl, slot_nrd, slot_nwr}, 4'hF);
    chk("async d_oe", slot_d_oe, 0);
    chk("async ready", req_ready, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("rst no rsp", rsp_valid, 0);
    end
    slot_nreset = 1'b1;
    last_rd = 8'h00;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("post rst no rsp", rsp_valid, 0);
    end
    run(vecs[1]);

`ifdef SLOT_NWAIT_EN
    // Two wait states, data changes during the waits.
    @(negedge clk);
    slot_d_in = 8'h11; slot_nwait = 1'b1;
    req_write = 1'b0; req_address = 16'hA000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c <= 30; c++) begin
      if (c == 11) slot_nwait = 1'b0;
      if (c == 20) begin slot_nwait = 1'b1; slot_d_in = 8'h99; end
      chk($sformatf("wait nrd c%0d", c), slot_nrd, !(c >= 3 && c <= 26));
      chk($sformatf("wait rsp c%0d", c), rsp_valid, c == 30);
      if (c == 30) begin
        chk("wait rdata", rsp_rdata, 8'h99);
        chk("wait error", rsp_error, 0);
      end
      if (c < 30) @(negedge clk);
    end
    // Wait stuck low: abort after MAX_WAIT=3 wait states.
    @(negedge clk);
    slot_nwait = 1'b0;
    req_write = 1'b0; req_address = 16'hB000; req_valid = 1'b1;
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 0; c <= 36; c++) begin
      chk($sformatf("tmo nrd c%0d", c), slot_nrd, !(c >= 3 && c <= 32));
      chk($sformatf("tmo nmerq c%0d", c), slot_nmerq, !(c >= 3 && c <= 32));
      chk($sformatf("tmo rsp c%0d", c), rsp_valid, c == 36);
      if (c == 36) begin
        chk("tmo error", rsp_error, 1);
        chk("tmo rdata", rsp_rdata, 8'hFF);
      end
      if (c < 36) @(negedge clk);
    end
    slot_nwait = 1'b1;
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
